// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Request/result bundle between the EX stage and muldiv_unit.
// Revision    : 1.0
// ============================================================================
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            mthi;
    logic            mtlo;
    logic [XLEN-1:0] wdata;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, a, b, flush, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative radix-2 MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Revision    : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    muldiv_if.slave   bus
);
    localparam int CNT_W = $clog2(ITER);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ITER - 1);

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_count;
    logic [1:0]      r_op;
    logic            r_sign_a;
    logic            r_sign_b;
    logic [XLEN-1:0] r_a_orig;
    logic [XLEN-1:0] r_opnd;   // multiplicand (mult) or divisor (div)
    logic [XLEN-1:0] r_acc;    // product upper half or partial remainder
    logic [XLEN-1:0] r_q;      // multiplier shifting out, quotient shifting in
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic            r_done;

    // ------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------
    logic            w_signed_req;
    logic            w_div_req;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;

    assign w_signed_req = ~bus.op[0];
    assign w_div_req    = bus.op[1];
    assign w_neg_a      = w_signed_req & bus.a[XLEN-1];
    assign w_neg_b      = w_signed_req & bus.b[XLEN-1];
    assign w_a_mag      = w_neg_a ? (~bus.a + 1'b1) : bus.a;
    assign w_b_mag      = w_neg_b ? (~bus.b + 1'b1) : bus.b;

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply / restoring divide
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_rem_sh;
    logic            w_rem_ge;
    logic [XLEN-1:0] w_rem_sub;

    assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    assign w_rem_sh  = {r_acc, r_q[XLEN-1]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_opnd});
    // A successful trial always fits in XLEN bits because it is below the divisor.
    assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_opnd;

    // ------------------------------------------------------------------
    // Sign fix-up
    // ------------------------------------------------------------------
    logic            w_is_div;
    logic            w_is_signed;
    logic            w_div_zero;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_neg;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_hi_next;
    logic [XLEN-1:0] w_lo_next;

    assign w_is_div    = r_op[1];
    assign w_is_signed = ~r_op[0];
    assign w_div_zero  = (r_opnd == '0);
    assign w_prod      = {r_acc, r_q};
    assign w_prod_neg  = ~w_prod + 1'b1;
    assign w_quo_fix   = (w_is_signed & (r_sign_a ^ r_sign_b)) ? (~r_q + 1'b1) : r_q;
    assign w_rem_fix   = (w_is_signed & r_sign_a) ? (~r_acc + 1'b1) : r_acc;

    always_comb begin
        w_hi_next = w_prod[2*XLEN-1:XLEN];
        w_lo_next = w_prod[XLEN-1:0];
        if (w_is_div) begin
            if (w_div_zero) begin
                // Divide by zero reports the untouched dividend and an all-ones quotient.
                w_hi_next = r_a_orig;
                w_lo_next = '1;
            end else begin
                w_hi_next = w_rem_fix;
                w_lo_next = w_quo_fix;
            end
        end else if (w_is_signed & (r_sign_a ^ r_sign_b)) begin
            w_hi_next = w_prod_neg[2*XLEN-1:XLEN];
            w_lo_next = w_prod_neg[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_a_orig <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        r_state  <= S_CALC;
                        r_count  <= '0;
                        r_op     <= bus.op;
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_a_orig <= bus.a;
                        r_acc    <= '0;
                        r_opnd   <= w_div_req ? w_b_mag : w_a_mag;
                        r_q      <= w_div_req ? w_a_mag : w_b_mag;
                    end else begin
                        if (bus.mthi) r_hi <= bus.wdata;
                        if (bus.mtlo) r_lo <= bus.wdata;
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (w_is_div) begin
                            r_acc <= w_rem_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];
                            r_q   <= {r_q[XLEN-2:0], w_rem_ge};
                        end else begin
                            r_acc <= w_mul_sum[XLEN:1];
                            r_q   <= {w_mul_sum[0], r_q[XLEN-1:1]};
                        end
                        r_count <= r_count + 1'b1;
                        if (r_count == C_LAST) r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    if (!bus.flush) begin
                        r_hi   <= w_hi_next;
                        r_lo   <= w_lo_next;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_unit;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output logic seen);
        int guard;
        guard = 0;
        seen  = 1'b0;
        while (!bus.done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        seen = bus.done;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy_cyc;
        int guard;
        busy_cyc = 0;
        guard    = 0;
        @(negedge clk);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && guard < 100) begin
            if (bus.busy) busy_cyc++;
            guard++;
            @(negedge clk);
        end
        check({tag, ".done"}, 32'(bus.done), 32'd1);
        check({tag, ".busycyc"}, busy_cyc, 32'd33);
        check({tag, ".hi"}, bus.hi, exp_hi);
        check({tag, ".lo"}, bus.lo, exp_lo);
        @(negedge clk);
        check({tag, ".pulse"}, 32'(bus.done), 32'd0);
    endtask

    logic seen;

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.flush = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.hi", bus.hi, 32'h0);
        check("rst.lo", bus.lo, 32'h0);
        rst_n = 1'b1;

        run_op("mult_7_m3",   2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_min",    2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("div_m7_2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7_m2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu_100_7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
        run_op("divu_zero",   2'b11, 32'h1234,     32'd0,        32'h00001234, 32'hFFFFFFFF);
        run_op("div_zero",    2'b10, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'hFFFFFFFF);
        run_op("div_ovf",     2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

        // mthi and mtlo together
        @(negedge clk);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hAAAA;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        check("mthilo.hi", bus.hi, 32'hAAAA);
        check("mthilo.lo", bus.lo, 32'hAAAA);

        // flush mid-divide
        bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush.busy", 32'(bus.busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) seen = 1'b1;
            @(negedge clk);
        end
        check("flush.nodone", 32'(seen), 32'd0);
        check("flush.hi", bus.hi, 32'hAAAA);
        check("flush.lo", bus.lo, 32'hAAAA);

        // mthi while busy is dropped
        bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.mthi = 1'b1; bus.wdata = 32'h5555;
        @(negedge clk);
        bus.mthi = 1'b0;
        check("mthibusy.hi", bus.hi, 32'hAAAA);
        wait_done(seen);
        check("mthibusy.done", 32'(seen), 32'd1);
        check("mthibusy.rhi", bus.hi, 32'd0);
        check("mthibusy.rlo", bus.lo, 32'd15);
        @(negedge clk);

        // start wins over mtlo in the same cycle
        bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
        bus.mtlo = 1'b1; bus.wdata = 32'h2222;
        @(negedge clk);
        bus.start = 1'b0; bus.mtlo = 1'b0;
        check("startmtlo.busy", 32'(bus.busy), 32'd1);
        check("startmtlo.lo", bus.lo, 32'd15);
        wait_done(seen);
        check("startmtlo.done", 32'(seen), 32'd1);
        check("startmtlo.rlo", bus.lo, 32'd6);
        @(negedge clk);

        // asynchronous reset mid-CALC
        bus.op = 2'b00; bus.a = 32'd7; bus.b = 32'hFFFFFFFD; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("prerst.busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 32'(bus.busy), 32'd0);
        check("midrst.done", 32'(bus.done), 32'd0);
        check("midrst.hi", bus.hi, 32'd0);
        check("midrst.lo", bus.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 2'b01, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
